// File: rtl/move_sequencer_if.sv
// -----------------------------------------------------------------------------
// move_sequencer_if
// Bundles the request, handshake and committed-position signals of the
// move_sequencer.
//   slave  modport : used by move_sequencer (requests/checker results in,
//                    enables/handshake/position/status out)
//   master modport : used by whatever drives the sequencer (player input,
//                    gravity, test-position calculator, collision checker)
// Signals:
//   start, fall_tick, left_req, right_req, down_req, rotate_req, drop_req
//   test_pos_x, test_pos_y, test_rot        candidate position
//   chk_done, chk_ok                        collision checker result
//   fall_en .. drop_en                      one-hot move select
//   chk_req                                 collision check start pulse
//   ctrl_pos_x, ctrl_pos_y, ctrl_rot        committed position
//   active, lock_pulse, game_over           piece status
// Width macros BITS_X_POS / BITS_Y_POS / BITS_ROT default to 4 / 5 / 2.
// -----------------------------------------------------------------------------
`ifndef BITS_X_POS
`define BITS_X_POS 4
`endif
`ifndef BITS_Y_POS
`define BITS_Y_POS 5
`endif
`ifndef BITS_ROT
`define BITS_ROT 2
`endif

interface move_sequencer_if;
    logic                   start;
    logic                   fall_tick;
    logic                   left_req;
    logic                   right_req;
    logic                   down_req;
    logic                   rotate_req;
    logic                   drop_req;
    logic [`BITS_X_POS-1:0] test_pos_x;
    logic [`BITS_Y_POS-1:0] test_pos_y;
    logic [`BITS_ROT-1:0]   test_rot;
    logic                   chk_done;
    logic                   chk_ok;
    logic                   fall_en;
    logic                   left_en;
    logic                   right_en;
    logic                   down_en;
    logic                   rotate_en;
    logic                   drop_en;
    logic                   chk_req;
    logic [`BITS_X_POS-1:0] ctrl_pos_x;
    logic [`BITS_Y_POS-1:0] ctrl_pos_y;
    logic [`BITS_ROT-1:0]   ctrl_rot;
    logic                   active;
    logic                   lock_pulse;
    logic                   game_over;

    modport slave (
        input  start, fall_tick, left_req, right_req, down_req, rotate_req, drop_req,
        input  test_pos_x, test_pos_y, test_rot, chk_done, chk_ok,
        output fall_en, left_en, right_en, down_en, rotate_en, drop_en, chk_req,
        output ctrl_pos_x, ctrl_pos_y, ctrl_rot, active, lock_pulse, game_over
    );

    modport master (
        output start, fall_tick, left_req, right_req, down_req, rotate_req, drop_req,
        output test_pos_x, test_pos_y, test_rot, chk_done, chk_ok,
        input  fall_en, left_en, right_en, down_en, rotate_en, drop_en, chk_req,
        input  ctrl_pos_x, ctrl_pos_y, ctrl_rot, active, lock_pulse, game_over
    );
endinterface

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
// Per-piece move controller for the active Tetris block. Player and gravity
// requests are latched as pending flags and granted one at a time (priority
// fall > down > left > right > rotate > drop) as a one-hot enable to the
// test-position calculator. Each grant runs a chk_req/chk_done handshake with
// the collision checker; an accepted candidate is committed into ctrl_*, a
// rejected fall/down locks the piece. Drop repeats down moves until rejected.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : move_sequencer_if.slave (requests, checker result, enables,
//          chk_req, committed position, active / lock_pulse / game_over)
// Configuration macro: AUTO_REPEAT_EN -- when defined, holding left/right
// longer than DAS_CYCLES re-requests the move every ARR_CYCLES (requires
// ARR_CYCLES <= DAS_CYCLES). Undefined: only rising edges request moves.
// -----------------------------------------------------------------------------
`ifndef BITS_X_POS
`define BITS_X_POS 4
`endif
`ifndef BITS_Y_POS
`define BITS_Y_POS 5
`endif
`ifndef BITS_ROT
`define BITS_ROT 2
`endif

module move_sequencer #(
    parameter logic [`BITS_X_POS-1:0] SPAWN_X    = `BITS_X_POS'(4),
    parameter logic [`BITS_Y_POS-1:0] SPAWN_Y    = `BITS_Y_POS'(0),
    parameter logic [`BITS_ROT-1:0]   SPAWN_ROT  = `BITS_ROT'(0),
    parameter int                     DAS_CYCLES = 16,
    parameter int                     ARR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    move_sequencer_if.slave   bus
);

    // Pending-flag / enable bit positions; lower index wins arbitration.
    localparam int P_FALL  = 0;
    localparam int P_DOWN  = 1;
    localparam int P_LEFT  = 2;
    localparam int P_RIGHT = 3;
    localparam int P_ROT   = 4;
    localparam int P_DROP  = 5;

    localparam logic [5:0] EN_DOWN = 6'b000010;
    localparam logic [5:0] EN_DROP = 6'b100000;

`ifdef AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int                CNT_W    = $clog2(DAS_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_DAS    = CNT_W'(DAS_CYCLES);
    // Reloading here makes the counter hit C_DAS again ARR_CYCLES later.
    localparam logic [CNT_W-1:0]  C_RELOAD = CNT_W'(DAS_CYCLES - ARR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_WAITS,
        S_ISSUE,
        S_WAIT,
        S_DROP,
        S_LOCK
    } state_t;

    state_t                 r_state;
    logic [5:0]             r_pend;
    logic [5:0]             r_en;
    logic                   r_chk_req;
    logic [`BITS_X_POS-1:0] r_pos_x;
    logic [`BITS_Y_POS-1:0] r_pos_y;
    logic [`BITS_ROT-1:0]   r_rot;
    logic                   r_active;
    logic                   r_lock;
    logic                   r_game_over;
    logic                   r_drop_mode;
    logic                   r_prev_left;
    logic                   r_prev_right;
    logic                   r_prev_down;
    logic                   r_prev_rot;
    logic                   r_prev_drop;
    logic [CNT_W-1:0]       r_rep_cnt;
    logic                   r_rep_dir;   // 1 = right, 0 = left

    logic                   w_left_rise;
    logic                   w_right_rise;
    logic                   w_rep_held;
    logic                   w_rep_fire;
    logic [5:0]             w_edge;
    logic [5:0]             w_set;
    logic [5:0]             w_grant;

    assign w_left_rise  = bus.left_req  & ~r_prev_left;
    assign w_right_rise = bus.right_req & ~r_prev_right;

    // Auto-repeat counter: 1 on the press edge, counts held cycles, fires at
    // C_DAS and then every ARR_CYCLES. Restarts on release or on a new press
    // in either direction.
    assign w_rep_held = r_rep_dir ? bus.right_req : bus.left_req;
    assign w_rep_fire = REP_EN && (r_rep_cnt == C_DAS) && w_rep_held &&
                        !w_left_rise && !w_right_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_rep_dir <= 1'b0;
        end else if (w_left_rise || w_right_rise) begin
            r_rep_cnt <= CNT_W'(1);
            r_rep_dir <= w_right_rise;
        end else if (!w_rep_held) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt == C_DAS) begin
            r_rep_cnt <= C_RELOAD;
        end else if (r_rep_cnt != '0) begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_edge          = '0;
        w_edge[P_FALL]  = bus.fall_tick;
        w_edge[P_DOWN]  = bus.down_req   & ~r_prev_down;
        w_edge[P_LEFT]  = w_left_rise    | (w_rep_fire & ~r_rep_dir);
        w_edge[P_RIGHT] = w_right_rise   | (w_rep_fire &  r_rep_dir);
        w_edge[P_ROT]   = bus.rotate_req & ~r_prev_rot;
        w_edge[P_DROP]  = bus.drop_req   & ~r_prev_drop;
    end

    // Requests only mean something for a piece in play, and are swallowed
    // while a hard drop is running.
    assign w_set   = (r_active && !r_drop_mode) ? w_edge : 6'b0;

    // Isolate the lowest set pending bit = highest-priority request.
    assign w_grant = r_pend & (~r_pend + 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pend       <= '0;
            r_en         <= '0;
            r_chk_req    <= 1'b0;
            r_pos_x      <= '0;
            r_pos_y      <= '0;
            r_rot        <= '0;
            r_active     <= 1'b0;
            r_lock       <= 1'b0;
            r_game_over  <= 1'b0;
            r_drop_mode  <= 1'b0;
            r_prev_left  <= 1'b0;
            r_prev_right <= 1'b0;
            r_prev_down  <= 1'b0;
            r_prev_rot   <= 1'b0;
            r_prev_drop  <= 1'b0;
        end else begin
            r_prev_left  <= bus.left_req;
            r_prev_right <= bus.right_req;
            r_prev_down  <= bus.down_req;
            r_prev_rot   <= bus.rotate_req;
            r_prev_drop  <= bus.drop_req;
            r_pend       <= r_pend | w_set;
            r_chk_req    <= 1'b0;
            r_lock       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_active && !r_game_over && bus.start) begin
                        r_pos_x   <= SPAWN_X;
                        r_pos_y   <= SPAWN_Y;
                        r_rot     <= SPAWN_ROT;
                        r_chk_req <= 1'b1;
                        r_state   <= S_SPAWN;
                    end else if (r_active && (r_pend != 6'b0)) begin
                        r_pend <= (r_pend & ~w_grant) | w_set;
                        if (w_grant[P_DROP]) begin
                            // Drop itself is never checked; it just starts
                            // the chain of down moves.
                            r_en        <= EN_DROP;
                            r_drop_mode <= 1'b1;
                            r_state     <= S_DROP;
                        end else begin
                            r_en      <= w_grant;
                            r_chk_req <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_SPAWN: begin
                    r_state <= S_WAITS;
                end
                S_WAITS: begin
                    if (bus.chk_done) begin
                        if (bus.chk_ok) begin
                            r_active <= 1'b1;
                        end else begin
                            r_game_over <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.chk_done) begin
                        r_en <= '0;
                        if (bus.chk_ok) begin
                            r_pos_x <= bus.test_pos_x;
                            r_pos_y <= bus.test_pos_y;
                            r_rot   <= bus.test_rot;
                            r_state <= r_drop_mode ? S_DROP : S_IDLE;
                        end else if (r_en[P_FALL] || r_en[P_DOWN]) begin
                            // Piece cannot descend further: it locks here.
                            r_lock      <= 1'b1;
                            r_active    <= 1'b0;
                            r_pend      <= '0;
                            r_drop_mode <= 1'b0;
                            r_state     <= S_LOCK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    r_en      <= EN_DOWN;
                    r_chk_req <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_LOCK: begin
                    r_pend  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fall_en    = r_en[P_FALL];
    assign bus.down_en    = r_en[P_DOWN];
    assign bus.left_en    = r_en[P_LEFT];
    assign bus.right_en   = r_en[P_RIGHT];
    assign bus.rotate_en  = r_en[P_ROT];
    assign bus.drop_en    = r_en[P_DROP];
    assign bus.chk_req    = r_chk_req;
    assign bus.ctrl_pos_x = r_pos_x;
    assign bus.ctrl_pos_y = r_pos_y;
    assign bus.ctrl_rot   = r_rot;
    assign bus.active     = r_active;
    assign bus.lock_pulse = r_lock;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_move_sequencer.sv
`ifndef BITS_X_POS
`define BITS_X_POS 4
`endif
`ifndef BITS_Y_POS
`define BITS_Y_POS 5
`endif
`ifndef BITS_ROT
`define BITS_ROT 2
`endif

module tb_move_sequencer;

    // Enable vector order used by the scoreboard: {fall,down,left,right,rotate,drop}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_FALL  = 6'b100000;
    localparam logic [5:0] E_DOWN  = 6'b010000;
    localparam logic [5:0] E_LEFT  = 6'b001000;
    localparam logic [5:0] E_RIGHT = 6'b000100;
    localparam logic [5:0] E_ROT   = 6'b000010;
    localparam logic [1:0] K_CHK   = 2'b10;   // {chk_req, lock_pulse}
    localparam logic [1:0] K_LOCK  = 2'b01;

    typedef struct {
        logic [1:0]             kind;
        logic [5:0]             en;
        logic [`BITS_X_POS-1:0] x;
        logic [`BITS_Y_POS-1:0] y;
        logic [`BITS_ROT-1:0]   rot;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic r_done = 1'b0;
    logic r_ok   = 1'b0;
    logic r_spur = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    ev_t  q_ev[$];
    bit   q_ok[$];
    int   n_rep;

    always #5 clk = ~clk;

    move_sequencer_if bus();

    move_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Collision checker outputs (responder plus an occasional stray pulse).
    assign bus.chk_done = r_done | r_spur;
    assign bus.chk_ok   = r_ok   | r_spur;

    // Test-position calculator model.
    always_comb begin
        bus.test_pos_x = bus.ctrl_pos_x + `BITS_X_POS'(bus.right_en) - `BITS_X_POS'(bus.left_en);
        bus.test_pos_y = bus.ctrl_pos_y + `BITS_Y_POS'(bus.fall_en | bus.down_en);
        bus.test_rot   = bus.ctrl_rot   + `BITS_ROT'(bus.rotate_en);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_chk(input logic [5:0] en, input int x, input int y, input int rot, input bit ok);
        ev_t e;
        e.kind = K_CHK;
        e.en   = en;
        e.x    = `BITS_X_POS'(x);
        e.y    = `BITS_Y_POS'(y);
        e.rot  = `BITS_ROT'(rot);
        q_ev.push_back(e);
        q_ok.push_back(ok);
    endtask

    task automatic exp_lock(input int x, input int y, input int rot);
        ev_t e;
        e.kind = K_LOCK;
        e.en   = E_NONE;
        e.x    = `BITS_X_POS'(x);
        e.y    = `BITS_Y_POS'(y);
        e.rot  = `BITS_ROT'(rot);
        q_ev.push_back(e);
    endtask

    task automatic check_pos(input string name, input int x, input int y, input int rot);
        check({name, "_x"},   bus.ctrl_pos_x, x);
        check({name, "_y"},   bus.ctrl_pos_y, y);
        check({name, "_rot"}, bus.ctrl_rot,   rot);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    // Monitor: every chk_req or lock_pulse must match the next expected event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.chk_req || bus.lock_pulse)) begin
                if (q_ev.size() == 0) begin
                    check("sb_extra_event", {bus.chk_req, bus.lock_pulse}, 0);
                end else begin
                    e = q_ev.pop_front();
                    check("sb_kind", {bus.chk_req, bus.lock_pulse}, e.kind);
                    check("sb_en", {bus.fall_en, bus.down_en, bus.left_en, bus.right_en,
                                    bus.rotate_en, bus.drop_en}, e.en);
                    check("sb_x",   bus.ctrl_pos_x, e.x);
                    check("sb_y",   bus.ctrl_pos_y, e.y);
                    check("sb_rot", bus.ctrl_rot,   e.rot);
                    if (e.kind == K_LOCK) check("sb_lock_active", bus.active, 0);
                end
            end
        end
    end

    // Collision checker: answers each chk_req one cycle later.
    initial begin
        bit ok;
        forever begin
            @(negedge clk);
            if (!rst && bus.chk_req) begin
                ok = (q_ok.size() != 0) ? q_ok.pop_front() : 1'b0;
                @(posedge clk);
                #1;
                r_done = 1'b1;
                r_ok   = ok;
                @(posedge clk);
                #1;
                r_done = 1'b0;
                r_ok   = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.fall_tick  = 1'b0;
        bus.left_req   = 1'b0;
        bus.right_req  = 1'b0;
        bus.down_req   = 1'b0;
        bus.rotate_req = 1'b0;
        bus.drop_req   = 1'b0;
        cyc(3);
        @(negedge clk);
        check_pos("rst", 0, 0, 0);
        check("rst_active",    bus.active,     0);
        check("rst_game_over", bus.game_over,  0);
        check("rst_lock",      bus.lock_pulse, 0);
        check("rst_chk_req",   bus.chk_req,    0);
        check("rst_en", {bus.fall_en, bus.down_en, bus.left_en, bus.right_en,
                         bus.rotate_en, bus.drop_en}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Spawn accepted.
        exp_chk(E_NONE, 4, 0, 0, 1);
        pulse_start();
        cyc(6);
        check("spawn_active", bus.active, 1);
        check_pos("spawn", 4, 0, 0);

        // Fall and left in the same cycle: fall first, then left.
        exp_chk(E_FALL, 4, 0, 0, 1);
        exp_chk(E_LEFT, 4, 1, 0, 1);
        bus.fall_tick = 1'b1;
        bus.left_req  = 1'b1;
        cyc(1);
        bus.fall_tick = 1'b0;
        bus.left_req  = 1'b0;
        cyc(12);
        check_pos("fall_left", 3, 1, 0);

        // Rotate rejected: nothing changes, no lock.
        exp_chk(E_ROT, 3, 1, 0, 0);
        bus.rotate_req = 1'b1;
        cyc(1);
        bus.rotate_req = 1'b0;
        cyc(8);
        check_pos("rot_rej", 3, 1, 0);
        check("rot_rej_active", bus.active, 1);

        // Left and right together: left wins, right stays pending.
        exp_chk(E_LEFT,  3, 1, 0, 1);
        exp_chk(E_RIGHT, 2, 1, 0, 1);
        bus.left_req  = 1'b1;
        bus.right_req = 1'b1;
        cyc(1);
        bus.left_req  = 1'b0;
        bus.right_req = 1'b0;
        cyc(12);
        check_pos("left_right", 3, 1, 0);

        // Fall, down, left together; a second left edge while pending does not queue.
        exp_chk(E_FALL, 3, 1, 0, 1);
        exp_chk(E_DOWN, 3, 2, 0, 1);
        exp_chk(E_LEFT, 3, 3, 0, 1);
        bus.fall_tick = 1'b1;
        bus.down_req  = 1'b1;
        bus.left_req  = 1'b1;
        cyc(1);
        bus.fall_tick = 1'b0;
        bus.down_req  = 1'b0;
        bus.left_req  = 1'b0;
        cyc(1);
        bus.left_req  = 1'b1;
        cyc(1);
        bus.left_req  = 1'b0;
        cyc(16);
        check_pos("multi", 2, 3, 0);

        // Stray chk_done in IDLE and start while active are both ignored.
        r_spur    = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        r_spur    = 1'b0;
        bus.start = 1'b0;
        cyc(4);
        check_pos("stray", 2, 3, 0);
        check("stray_active", bus.active, 1);

        // Down rejected: piece locks in place.
        exp_chk(E_DOWN, 2, 3, 0, 0);
        exp_lock(2, 3, 0);
        bus.down_req = 1'b1;
        cyc(1);
        bus.down_req = 1'b0;
        cyc(8);
        check("lock_active", bus.active, 0);
        check_pos("lock", 2, 3, 0);

        // New piece, then hard drop: ok for y=1..5, reject y=6.
        exp_chk(E_NONE, 4, 0, 0, 1);
        pulse_start();
        cyc(6);
        check("spawn2_active", bus.active, 1);
        for (int y = 0; y < 5; y++) exp_chk(E_DOWN, 4, y, 0, 1);
        exp_chk(E_DOWN, 4, 5, 0, 0);
        exp_lock(4, 5, 0);
        bus.drop_req = 1'b1;
        cyc(1);
        bus.drop_req = 1'b0;
        cyc(3);
        bus.left_req  = 1'b1;   // ignored during the drop
        bus.fall_tick = 1'b1;
        cyc(1);
        bus.left_req  = 1'b0;
        bus.fall_tick = 1'b0;
        cyc(40);
        check_pos("drop", 4, 5, 0);
        check("drop_active", bus.active, 0);

        // Spawn rejected: game over, later start ignored.
        exp_chk(E_NONE, 4, 0, 0, 0);
        pulse_start();
        cyc(6);
        check("go_flag",   bus.game_over, 1);
        check("go_active", bus.active,    0);
        pulse_start();
        cyc(6);
        check("go_sticky", bus.game_over, 1);

        rst = 1'b1;
        cyc(2);
        check("rst2_game_over", bus.game_over, 0);
        check_pos("rst2", 0, 0, 0);
        rst = 1'b0;
        cyc(1);

        // Reset in the middle of a move handshake aborts it without a lock.
        exp_chk(E_NONE, 4, 0, 0, 1);
        pulse_start();
        cyc(6);
        check("spawn3_active", bus.active, 1);
        exp_chk(E_RIGHT, 4, 0, 0, 1);
        bus.right_req = 1'b1;
        cyc(1);
        bus.right_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.chk_req && n < 20);
        check("abort_chk_req_seen", bus.chk_req, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(3);
        check("abort_lock", bus.lock_pulse, 0);
        rst = 1'b0;
        cyc(3);
        check("abort_active", bus.active, 0);
        check_pos("abort", 0, 0, 0);

        // Right held for 40 cycles.
`ifdef AUTO_REPEAT_EN
        n_rep = 7;
`else
        n_rep = 1;
`endif
        exp_chk(E_NONE, 4, 0, 0, 1);
        pulse_start();
        cyc(6);
        for (int i = 0; i < n_rep; i++) exp_chk(E_RIGHT, 4 + i, 0, 0, 1);
        bus.right_req = 1'b1;
        cyc(40);
        bus.right_req = 1'b0;
        cyc(14);
        check_pos("hold_right", 4 + n_rep, 0, 0);

        check("sb_drain",  q_ev.size(), 0);
        check("rsp_drain", q_ok.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
